commit_rob: RTL and testbench



---
 rtl/commit_rob.sv | 136 +++++++++++++
 tb/tb_commit_rob.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_rob.sv
// In-order commit buffer: grants sequence numbers, collects out-of-order completions,
// retires one entry per cycle in order. Optional squash via `COMMIT_ROB_FLUSH_EN (adds flush port).
module commit_rob #(
    parameter int unsigned p_seq_num_bits = 5,
    parameter int unsigned p_depth        = 8,
    parameter int unsigned p_addr_bits    = 32,
    parameter int unsigned p_data_bits    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_val,
    output logic                      alloc_rdy,
    output logic [p_seq_num_bits-1:0] alloc_seq_num,
    input  logic                      complete_val,
    input  logic [p_seq_num_bits-1:0] complete_seq_num,
    input  logic [p_addr_bits-1:0]    complete_pc,
    input  logic [4:0]                complete_waddr,
    input  logic [p_data_bits-1:0]    complete_wdata,
    input  logic                      complete_wen,
`ifdef COMMIT_ROB_FLUSH_EN
    input  logic                      flush,
`endif
    output logic                      commit_val,
    output logic [p_addr_bits-1:0]    commit_pc,
    output logic [p_seq_num_bits-1:0] commit_seq_num,
    output logic [4:0]                commit_waddr,
    output logic [p_data_bits-1:0]    commit_wdata,
    output logic                      commit_wen
);

    localparam int unsigned SW    = p_seq_num_bits;
    localparam int unsigned IDX_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CNT_W = $clog2(p_depth + 1);

    logic [SW-1:0]      head_q, head_d;
    logic [SW-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [p_depth-1:0] alloc_q, alloc_d;
    logic [p_depth-1:0] done_q, done_d;

    logic [p_addr_bits-1:0] pc_q    [p_depth];
    logic [4:0]             waddr_q [p_depth];
    logic [p_data_bits-1:0] wdata_q [p_depth];
    logic [p_depth-1:0]     wen_q;

    logic [IDX_W-1:0] head_idx, tail_idx, cmp_idx;
    logic             alloc_fire;
    logic             complete_en;

    assign head_idx = IDX_W'(head_q);
    assign tail_idx = IDX_W'(tail_q);
    assign cmp_idx  = IDX_W'(complete_seq_num);

    // Handshake and retire outputs depend only on registered state (plus flush)
`ifdef COMMIT_ROB_FLUSH_EN
    assign alloc_rdy   = (count_q != CNT_W'(p_depth)) && !flush;
    assign complete_en = complete_val && !flush;
`else
    assign alloc_rdy   = (count_q != CNT_W'(p_depth));
    assign complete_en = complete_val;
`endif
    assign alloc_seq_num = tail_q;
    assign alloc_fire    = alloc_val && alloc_rdy;

    assign commit_val     = alloc_q[head_idx] && done_q[head_idx];
    assign commit_seq_num = head_q;
    assign commit_pc      = pc_q[head_idx];
    assign commit_waddr   = waddr_q[head_idx];
    assign commit_wdata   = wdata_q[head_idx];
    assign commit_wen     = wen_q[head_idx];

    // Next-state: retire head, mark completion, allocate at tail, then squash if flushing
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        alloc_d = alloc_q;
        done_d  = done_q;

        if (commit_val) begin
            alloc_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + SW'(1);
        end
        if (complete_en) begin
            done_d[cmp_idx] = 1'b1;
        end
        if (alloc_fire) begin
            alloc_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + SW'(1);
        end

        unique case ({alloc_fire, commit_val})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

`ifdef COMMIT_ROB_FLUSH_EN
        if (flush) begin
            alloc_d = '0;
            done_d  = '0;
            tail_d  = head_d;
            count_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
        end
    end

    // Payload storage needs no reset; validity lives in alloc/done bits
    always_ff @(posedge clk) begin
        if (complete_en) begin
            pc_q[cmp_idx]    <= complete_pc;
            waddr_q[cmp_idx] <= complete_waddr;
            wdata_q[cmp_idx] <= complete_wdata;
            wen_q[cmp_idx]   <= complete_wen;
        end
    end

endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob: reset, in-order/out-of-order retire, full, wrap,
// and flush when COMMIT_ROB_FLUSH_EN is defined.
module tb_commit_rob;

    logic        clk;
    logic        rst;
    logic        alloc_val;
    logic        alloc_rdy;
    logic [4:0]  alloc_seq_num;
    logic        complete_val;
    logic [4:0]  complete_seq_num;
    logic [31:0] complete_pc;
    logic [4:0]  complete_waddr;
    logic [31:0] complete_wdata;
    logic        complete_wen;
`ifdef COMMIT_ROB_FLUSH_EN
    logic        flush;
`endif
    logic        commit_val;
    logic [31:0] commit_pc;
    logic [4:0]  commit_seq_num;
    logic [4:0]  commit_waddr;
    logic [31:0] commit_wdata;
    logic        commit_wen;

    int n_pass  = 0;
    int n_total = 0;

    commit_rob #(
        .p_seq_num_bits(5),
        .p_depth       (8),
        .p_addr_bits   (32),
        .p_data_bits   (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_val       (alloc_val),
        .alloc_rdy       (alloc_rdy),
        .alloc_seq_num   (alloc_seq_num),
        .complete_val    (complete_val),
        .complete_seq_num(complete_seq_num),
        .complete_pc     (complete_pc),
        .complete_waddr  (complete_waddr),
        .complete_wdata  (complete_wdata),
        .complete_wen    (complete_wen),
`ifdef COMMIT_ROB_FLUSH_EN
        .flush           (flush),
`endif
        .commit_val      (commit_val),
        .commit_pc       (commit_pc),
        .commit_seq_num  (commit_seq_num),
        .commit_waddr    (commit_waddr),
        .commit_wdata    (commit_wdata),
        .commit_wen      (commit_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pc_of(input int s);
        return 32'h0000_1000 + 32'(s) * 32'd4;
    endfunction
    function automatic logic [31:0] wdata_of(input int s);
        return 32'hDEAD_0000 ^ (32'(s) * 32'h0101_0101);
    endfunction
    function automatic logic [4:0] waddr_of(input int s);
        return 5'(s + 3);
    endfunction
    function automatic logic wen_of(input int s);
        return (s % 2) == 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_val        = 1'b0;
        complete_val     = 1'b0;
        complete_seq_num = '0;
        complete_pc      = '0;
        complete_waddr   = '0;
        complete_wdata   = '0;
        complete_wen     = 1'b0;
`ifdef COMMIT_ROB_FLUSH_EN
        flush            = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_complete(input int s);
        complete_val     = 1'b1;
        complete_seq_num = 5'(s);
        complete_pc      = pc_of(s);
        complete_waddr   = waddr_of(s);
        complete_wdata   = wdata_of(s);
        complete_wen     = wen_of(s);
    endtask

    task automatic chk_commit(input int s);
        chk("commit_val",   64'(commit_val),     64'd1);
        chk("commit_seq",   64'(commit_seq_num), 64'(s % 32));
        chk("commit_pc",    64'(commit_pc),      64'(pc_of(s)));
        chk("commit_waddr", 64'(commit_waddr),   64'(waddr_of(s)));
        chk("commit_wdata", 64'(commit_wdata),   64'(wdata_of(s)));
        chk("commit_wen",   64'(commit_wen),     64'(wen_of(s)));
    endtask

    task automatic alloc_n(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            chk("alloc_rdy", 64'(alloc_rdy),     64'd1);
            chk("alloc_seq", 64'(alloc_seq_num), 64'((first + i) % 32));
            alloc_val = 1'b1;
            tick();
        end
        alloc_val = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state
        chk("rst_alloc_rdy",  64'(alloc_rdy),     64'd1);
        chk("rst_alloc_seq",  64'(alloc_seq_num), 64'd0);
        chk("rst_commit_val", 64'(commit_val),    64'd0);

        // In-order completion: each commits the cycle after its completion
        alloc_n(3, 0);
        chk("empty_done_commit_val", 64'(commit_val), 64'd0);
        for (int s = 0; s < 3; s++) begin
            drive_complete(s);
            tick();
            chk_commit(s);
        end
        complete_val = 1'b0;
        tick();
        chk("inorder_drain", 64'(commit_val), 64'd0);

        // Out-of-order: younger done entries wait behind an incomplete head
        do_reset();
        alloc_n(3, 0);
        drive_complete(2);
        tick();
        chk("ooo_after2", 64'(commit_val), 64'd0);
        drive_complete(1);
        tick();
        chk("ooo_after1", 64'(commit_val), 64'd0);
        drive_complete(0);
        tick();
        complete_val = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk_commit(s);
            tick();
        end
        chk("ooo_drain", 64'(commit_val), 64'd0);

        // Full: same-cycle commit does not open a slot for allocation
        do_reset();
        alloc_n(8, 0);
        chk("full_rdy", 64'(alloc_rdy), 64'd0);
        alloc_val = 1'b1;
        tick();
        chk("full_9th_rdy", 64'(alloc_rdy),     64'd0);
        chk("full_9th_seq", 64'(alloc_seq_num), 64'd8);
        drive_complete(0);
        tick();
        complete_val = 1'b0;
        chk_commit(0);
        chk("full_commit_rdy", 64'(alloc_rdy), 64'd0);
        tick();
        chk("full_freed_rdy", 64'(alloc_rdy),     64'd1);
        chk("full_freed_seq", 64'(alloc_seq_num), 64'd8);
        chk("full_freed_cv",  64'(commit_val),    64'd0);
        tick();
        alloc_val = 1'b0;
        chk("full_grant8_seq", 64'(alloc_seq_num), 64'd9);
        chk("full_grant8_rdy", 64'(alloc_rdy),     64'd0);

        // Streaming wrap: alloc each cycle, complete the previous grant, commit every cycle
        do_reset();
        for (int c = 0; c < 42; c++) begin
            alloc_val = (c < 40);
            if (c < 40) chk("wrap_alloc_seq", 64'(alloc_seq_num), 64'(c % 32));
            if (c >= 1 && c <= 40) drive_complete((c - 1) % 32);
            else complete_val = 1'b0;
            tick();
            if (c >= 1 && c <= 40) chk_commit((c - 1) % 32);
            else chk("wrap_idle", 64'(commit_val), 64'd0);
        end
        idle_inputs();

`ifdef COMMIT_ROB_FLUSH_EN
        // Flush: head commit survives, everything younger is squashed
        do_reset();
        alloc_n(5, 0);
        drive_complete(3);
        tick();
        chk("fl_wait_head", 64'(commit_val), 64'd0);
        drive_complete(0);
        tick();
        chk_commit(0);
        flush     = 1'b1;
        alloc_val = 1'b1;
        drive_complete(4);
        #1;
        chk("fl_rdy_forced", 64'(alloc_rdy), 64'd0);
        tick();
        idle_inputs();
        chk("fl_post_cv",  64'(commit_val),    64'd0);
        chk("fl_post_seq", 64'(alloc_seq_num), 64'd1);
        chk("fl_post_rdy", 64'(alloc_rdy),     64'd1);
        tick();
        tick();
        chk("fl_3_gone", 64'(commit_val), 64'd0);
        alloc_n(8, 1);
        chk("fl_count0_full", 64'(alloc_rdy), 64'd0);
        drive_complete(1);
        tick();
        complete_val = 1'b0;
        chk_commit(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
